k16_frame_buffer_arbiter: RTL and testbench

Shares the single-port 2048×16 synchronous-read frame buffer RAM between the VGA text/graphics scan-out engine and the K16 CPU bus. Video reads have absolute priority and are never stalled. CPU writes are posted through a small FIFO and drained in idle RAM cycles. CPU reads block until all posted writes have drained, then take the next idle RAM cycle. The block sits between the video generator, the CPU bus interface and the RAM macro.

---
 rtl/k16_frame_buffer_arbiter.sv | 148 ++++++++++++++
 tb/tb_k16_frame_buffer_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k16_frame_buffer_arbiter.sv
// Frame buffer RAM arbiter: video scan-out reads always win; CPU writes are posted
// through a small FIFO and CPU reads wait until every posted write has committed.
module k16_frame_buffer_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         video_addr,
  input  logic                          video_want_read,
  output logic [DATA_WIDTH-1:0]         video_data,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic [DATA_WIDTH-1:0]         cpu_wdata,
  output logic                          cpu_ready,
  output logic                          cpu_rvalid,
  output logic [DATA_WIDTH-1:0]         cpu_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_WIDTH-1:0]         mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_vgrant_d;
  logic [DATA_WIDTH-1:0] r_video_q;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;

  logic w_fifo_empty;
  logic w_fifo_full;
  logic w_wr_gnt;
  logic w_rd_gnt;
  logic w_push;
  logic w_pop;
  logic w_rd_accept;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));

  // Fixed priority: video, then the oldest posted write, then a pending CPU read.
  assign w_wr_gnt = !video_want_read && !w_fifo_empty;
  assign w_rd_gnt = !video_want_read && w_fifo_empty && (r_state == ST_RD_ISSUE);

  assign w_push      = cpu_req && cpu_ready && cpu_we;
  assign w_rd_accept = cpu_req && cpu_ready && !cpu_we;
  assign w_pop       = w_wr_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_rd_accept) w_state_next = ST_RD_ISSUE;
      ST_RD_ISSUE: if (w_rd_gnt) w_state_next = ST_RD_WAIT;
      ST_RD_WAIT:  w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Ready looks only at registered state, so a full FIFO never sees a push.
  always_comb begin
    cpu_ready  = (r_state == ST_IDLE) && !w_fifo_full && !reset;
    cpu_rvalid = (r_state == ST_RD_WAIT);
  end

  always_comb begin
    mem_addr  = video_addr;
    mem_wdata = r_fifo_data[r_rd_ptr];
    mem_we    = 1'b0;
    if (w_wr_gnt) begin
      mem_addr = r_fifo_addr[r_rd_ptr];
      mem_we   = !reset;
    end else if (w_rd_gnt) begin
      mem_addr = r_rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= cpu_addr;
      r_fifo_data[r_wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fifo_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_addr   <= '0;
      r_vgrant_d  <= 1'b0;
      r_video_q   <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (w_rd_accept) r_rd_addr <= cpu_addr;
      r_vgrant_d <= video_want_read;
      if (r_vgrant_d) r_video_q <= mem_rdata;
      if (r_state == ST_RD_WAIT) r_cpu_rdata <= mem_rdata;
    end
  end

  // RAM data is forwarded in the cycle it arrives and held afterwards.
  assign video_data = r_vgrant_d ? mem_rdata : r_video_q;
  assign cpu_rdata  = (r_state == ST_RD_WAIT) ? mem_rdata : r_cpu_rdata;

endmodule

// File: tb/tb_k16_frame_buffer_arbiter.sv
// Self-checking bench for k16_frame_buffer_arbiter: directed scenarios plus a
// randomized run checked against a shadow-memory / posted-write-queue model.
module tb_k16_frame_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] video_addr;
  logic        video_want_read;
  logic [15:0] video_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [2:0]  fifo_count;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  k16_frame_buffer_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .video_addr(video_addr), .video_want_read(video_want_read), .video_data(video_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fifo_count(fifo_count),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Synchronous-read single-port RAM model (2048 x 16).
  logic [15:0] ram [0:2047];
  logic [15:0] ram_q;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    ram_q <= ram[mem_addr];
  end
  assign mem_rdata = ram_q;

  // One cycle: inputs change just after the edge, outputs are sampled 1 time unit later.
  task automatic step(input logic vr, input logic [10:0] va, input logic rq, input logic we,
                      input logic [10:0] a, input logic [15:0] d);
    @(posedge clk);
    #1;
    video_want_read = vr;
    video_addr      = va;
    cpu_req         = rq;
    cpu_we          = we;
    cpu_addr        = a;
    cpu_wdata       = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    video_want_read = 1'b0; video_addr = '0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_wdata = 16'hFFFF;
    #12;
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cpu_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", cpu_rvalid); end
    total++; if (cpu_rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h want 0000", cpu_rdata); end
    total++; if (video_data !== 16'h0000) begin bad++; $display("FAIL rst_video: got %h want 0000", video_data); end
    cpu_req = 1'b0;
    @(posedge clk); #2; reset = 1'b0;
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cpu_ready); end
    $display("tx reset released");
  endtask

  task automatic test_video_only;
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h000, 16'h1234);
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h028, 16'hABCD);
    idle(2);
    step(1'b1, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL vid_we0: got %b want 0", mem_we); end
    total++; if (mem_addr !== 11'h000) begin bad++; $display("FAIL vid_addr0: got %h want 000", mem_addr); end
    step(1'b1, 11'h028, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if (video_data !== 16'h1234) begin bad++; $display("FAIL vid_data0: got %h want 1234", video_data); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL vid_we1: got %b want 0", mem_we); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if (video_data !== 16'hABCD) begin bad++; $display("FAIL vid_data1: got %h want abcd", video_data); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if (video_data !== 16'hABCD) begin bad++; $display("FAIL vid_hold: got %h want abcd", video_data); end
    $display("tx video reads 000->1234 028->abcd");
  endtask

  task automatic test_posted_writes;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 11'h000, (i < 4), 1'b1, 11'(11'h100 + i), 16'(16'hA0 + i));
      if (i < 4) begin
        total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL pw_ready[%0d]: got %b want 1", i, cpu_ready); end
      end
      total++; if (fifo_count !== ((i == 0) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL pw_count[%0d]: got %0d", i, fifo_count); end
      if (i == 0) begin
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL pw_we[0]: got %b want 0", mem_we); end
      end else begin
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'(11'h100 + i - 1), 16'(16'hA0 + i - 1)}) begin
          bad++; $display("FAIL pw_commit[%0d]: got we=%b %h<-%h want %h<-%h", i, mem_we, mem_addr, mem_wdata, 11'(11'h100 + i - 1), 16'(16'hA0 + i - 1));
        end
      end
    end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({mem_we, fifo_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL pw_done: got we=%b count=%0d want 0/0", mem_we, fifo_count); end
    $display("tx posted writes 100..103");
  endtask

  task automatic test_full_fifo;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 11'h000, 1'b1, 1'b1, 11'(11'h300 + k), 16'(16'hC0 + k));
      total++; if ({cpu_ready, mem_we} !== 2'b10) begin bad++; $display("FAIL ff_accept[%0d]: got ready=%b we=%b want 1/0", k, cpu_ready, mem_we); end
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 11'h000, 1'b1, 1'b1, 11'h304, 16'h00C4);
      total++; if ({cpu_ready, fifo_count} !== {1'b0, 3'd4}) begin bad++; $display("FAIL ff_full[%0d]: got ready=%b count=%0d want 0/4", k, cpu_ready, fifo_count); end
    end
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h304, 16'h00C4);
    total++; if (cpu_ready !== 1'b0) begin bad++; $display("FAIL ff_ready_at_pop: got %b want 0", cpu_ready); end
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'h300, 16'h00C0}) begin bad++; $display("FAIL ff_commit0: got we=%b %h<-%h", mem_we, mem_addr, mem_wdata); end
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h304, 16'h00C4);
    total++; if ({cpu_ready, fifo_count} !== {1'b1, 3'd3}) begin bad++; $display("FAIL ff_fifth: got ready=%b count=%0d want 1/3", cpu_ready, fifo_count); end
    total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'h301, 16'h00C1}) begin bad++; $display("FAIL ff_commit1: got we=%b %h<-%h", mem_we, mem_addr, mem_wdata); end
    for (int k = 2; k < 5; k++) begin
      step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
      total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'(11'h300 + k), 16'(16'hC0 + k)}) begin
        bad++; $display("FAIL ff_commit%0d: got we=%b %h<-%h", k, mem_we, mem_addr, mem_wdata);
      end
    end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({mem_we, fifo_count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL ff_drained: got we=%b count=%0d", mem_we, fifo_count); end
    $display("tx full fifo 300..304 under video");
  endtask

  task automatic test_raw;
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h200, 16'h5A5A);
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL raw_wready: got %b want 1", cpu_ready); end
    step(1'b0, 11'h000, 1'b1, 1'b0, 11'h200, 16'h0000);
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL raw_rready: got %b want 1", cpu_ready); end
    total++; if ({mem_we, mem_addr} !== {1'b1, 11'h200}) begin bad++; $display("FAIL raw_commit: got we=%b addr=%h", mem_we, mem_addr); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({mem_we, mem_addr, cpu_ready} !== {1'b0, 11'h200, 1'b0}) begin bad++; $display("FAIL raw_rgrant: got we=%b addr=%h ready=%b", mem_we, mem_addr, cpu_ready); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h5A5A}) begin bad++; $display("FAIL raw_rvalid: got v=%b data=%h want 1/5a5a", cpu_rvalid, cpu_rdata); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({cpu_rvalid, cpu_ready, cpu_rdata} !== {1'b0, 1'b1, 16'h5A5A}) begin bad++; $display("FAIL raw_after: got v=%b ready=%b data=%h", cpu_rvalid, cpu_ready, cpu_rdata); end
    $display("tx raw 200 <- 5a5a, read 5a5a");
  endtask

  task automatic test_contention;
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h400, 16'h1111);
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h401, 16'h2222);
    step(1'b0, 11'h000, 1'b1, 1'b1, 11'h500, 16'h7777);
    idle(2);
    step(1'b0, 11'h000, 1'b1, 1'b0, 11'h500, 16'h0000);
    total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL ct_accept: got %b want 1", cpu_ready); end
    step(1'b1, 11'h400, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if (mem_addr !== 11'h400) begin bad++; $display("FAIL ct_vid1_addr: got %h want 400", mem_addr); end
    step(1'b1, 11'h401, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({mem_addr, video_data} !== {11'h401, 16'h1111}) begin bad++; $display("FAIL ct_vid2: got addr=%h vdata=%h", mem_addr, video_data); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL ct_early_rvalid: got %b want 0", cpu_rvalid); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({mem_addr, mem_we, video_data} !== {11'h500, 1'b0, 16'h2222}) begin bad++; $display("FAIL ct_rgrant: got addr=%h we=%b vdata=%h", mem_addr, mem_we, video_data); end
    step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({cpu_rvalid, cpu_rdata, video_data} !== {1'b1, 16'h7777, 16'h2222}) begin bad++; $display("FAIL ct_rvalid: got v=%b data=%h vdata=%h", cpu_rvalid, cpu_rdata, video_data); end
    $display("tx contention read 500 -> 7777");
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) step(1'b1, 11'h000, 1'b1, 1'b1, 11'(11'h600 + k), 16'(16'hD0 + k));
    step(1'b1, 11'h000, 1'b1, 1'b0, 11'h600, 16'h0000);
    total++; if ({cpu_ready, fifo_count} !== {1'b1, 3'd3}) begin bad++; $display("FAIL ar_setup: got ready=%b count=%0d want 1/3", cpu_ready, fifo_count); end
    step(1'b1, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
    total++; if ({cpu_ready, fifo_count} !== {1'b0, 3'd3}) begin bad++; $display("FAIL ar_pending: got ready=%b count=%0d want 0/3", cpu_ready, fifo_count); end
    #2; reset = 1'b1; #1;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL ar_count: got %0d want 0", fifo_count); end
    total++; if ({cpu_ready, mem_we, cpu_rvalid} !== 3'b000) begin bad++; $display("FAIL ar_ctrl: got ready=%b we=%b rvalid=%b", cpu_ready, mem_we, cpu_rvalid); end
    total++; if ({cpu_rdata, video_data} !== 32'h0) begin bad++; $display("FAIL ar_data: got rdata=%h vdata=%h want 0", cpu_rdata, video_data); end
    idle(2);
    #2; reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 11'h000, 1'b0, 1'b0, 11'h000, 16'h0000);
      total++; if ({mem_we, cpu_rvalid, fifo_count} !== {1'b0, 1'b0, 3'd0}) begin
        bad++; $display("FAIL ar_after[%0d]: got we=%b rvalid=%b count=%0d", k, mem_we, cpu_rvalid, fifo_count);
      end
    end
    $display("tx async reset discarded 3 writes and a read");
  endtask

  typedef struct packed { logic [10:0] a; logic [15:0] d; } wr_t;

  task automatic test_random;
    wr_t         exp_wq[$];
    logic [15:0] exp_rq[$];
    logic [15:0] shadow [16];
    logic [15:0] exp_vid  = 16'h0000;
    logic [15:0] prev_val = 16'h0000;
    logic        prev_vid = 1'b0;
    int          rd_wait  = 0;
    wr_t         w;
    logic [15:0] r;
    logic vr, rq, we; logic [10:0] va, a; logic [15:0] d;
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 16'($urandom);
      step(1'b0, 11'h000, 1'b1, 1'b1, 11'(11'h700 + i), shadow[i]);
      total++; if (cpu_ready !== 1'b1) begin bad++; $display("FAIL rnd_init_ready[%0d]: got %b want 1", i, cpu_ready); end
    end
    idle(3);
    for (int c = 0; c < 900; c++) begin
      vr = (c < 800) && ($urandom_range(7) == 0);
      va = 11'(11'h700 + $urandom_range(15));
      rq = (c < 800) && ($urandom_range(1) == 1);
      we = 1'($urandom_range(1));
      a  = 11'(11'h700 + $urandom_range(15));
      d  = 16'($urandom);
      step(vr, va, rq, we, a, d);
      if (prev_vid) exp_vid = prev_val;
      total++; if (video_data !== exp_vid) begin bad++; $display("FAIL rnd_video[%0d]: got %h want %h", c, video_data, exp_vid); end
      total++; if (fifo_count !== 3'(exp_wq.size())) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, fifo_count, exp_wq.size()); end
      if (mem_we) begin
        total++;
        if (vr) begin bad++; $display("FAIL rnd_we_vs_video[%0d]: got we=1 want 0", c); end
        else if (exp_wq.size() == 0) begin bad++; $display("FAIL rnd_spurious_we[%0d]: got %h<-%h want none", c, mem_addr, mem_wdata); end
        else begin
          w = exp_wq.pop_front();
          if ({mem_addr, mem_wdata} !== {w.a, w.d}) begin bad++; $display("FAIL rnd_commit[%0d]: got %h<-%h want %h<-%h", c, mem_addr, mem_wdata, w.a, w.d); end
        end
      end
      if (cpu_rvalid) begin
        total++;
        if (exp_rq.size() == 0) begin bad++; $display("FAIL rnd_spurious_rvalid[%0d]: got %h want none", c, cpu_rdata); end
        else begin
          r = exp_rq.pop_front();
          if (cpu_rdata !== r) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, cpu_rdata, r); end
        end
      end
      if (rq && cpu_ready) begin
        if (we) begin
          w.a = a; w.d = d;
          exp_wq.push_back(w);
          shadow[a[3:0]] = d;
          $display("tx cyc=%0d write %h <- %h", c, a, d);
        end else begin
          exp_rq.push_back(shadow[a[3:0]]);
          $display("tx cyc=%0d read %h expect %h", c, a, shadow[a[3:0]]);
        end
      end
      prev_vid = vr;
      prev_val = ram[va];
      rd_wait = (exp_rq.size() != 0) ? rd_wait + 1 : 0;
      if (rd_wait > 40) begin
        total++; bad++; $display("FAIL rnd_read_timeout[%0d]: got no rvalid in 40 cycles want rvalid", c);
        rd_wait = 0;
      end
    end
    total++; if (exp_wq.size() != 0) begin bad++; $display("FAIL rnd_wq_left: got %0d want 0", exp_wq.size()); end
    total++; if (exp_rq.size() != 0) begin bad++; $display("FAIL rnd_rq_left: got %0d want 0", exp_rq.size()); end
  endtask

  initial begin
    test_reset();
    test_video_only();
    test_posted_writes();
    test_full_fifo();
    test_raw();
    test_contention();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
